// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiters.
// Holds default sizing, the grant FSM state type and mode encodings.
package mem_arb_pkg;

    localparam int PORTS_D    = 16;
    localparam int WEIGHT_W_D = 4;
    localparam int MAX_LOCK_D = 8;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_WRR = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular-priority picker: first set req bit at or after ptr.
// Ports: req, ptr in; pick (one-hot), pick_id, found out.
module rr_pick #(
    parameter int PORTS = 16,
    parameter int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [PORTS-1:0] pick,
    output logic [IDX_W-1:0] pick_id,
    output logic             found
);

    logic [PORTS-1:0]   mask;
    logic [2*PORTS-1:0] dbl;

    // Upper half is the unmasked copy, so the lowest set bit of the
    // doubled vector is the first requester scanning circularly.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl     = {req, req & mask};
        found   = |req;
        pick_id = '0;
        for (int i = 2*PORTS-1; i >= 0; i--) begin
            if (dbl[i]) pick_id = IDX_W'(i % PORTS);
        end
        pick = '0;
        if (found) pick[pick_id] = 1'b1;
    end

endmodule

// File: rtl/mem_wrr_arbiter.sv
// Round-robin / weighted round-robin memory-bank arbiter with bounded lock.
// Ports: clk, rst, mode, req, lock, weight in; gnt, gnt_valid, gnt_id, gnt_start out.
module mem_wrr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int PORTS    = PORTS_D,
    parameter int WEIGHT_W = WEIGHT_W_D,
    parameter int MAX_LOCK = MAX_LOCK_D,
    parameter int IDX_W    = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [PORTS-1:0]      req,
    input  logic [PORTS-1:0]      lock,
    input  logic [PORTS*WEIGHT_W-1:0] weight,
    output logic [PORTS-1:0]      gnt,
    output logic                  gnt_valid,
    output logic [IDX_W-1:0]      gnt_id,
    output logic                  gnt_start
);

    localparam int LK_W  = $clog2(MAX_LOCK);
    localparam int CNT_W = (WEIGHT_W > LK_W) ? WEIGHT_W : LK_W;

    arb_state_e        state;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [WEIGHT_W-1:0] weff;

    logic [IDX_W-1:0]  nxt;
    logic [IDX_W-1:0]  scan_ptr;
    logic [PORTS-1:0]  pick;
    logic [IDX_W-1:0]  pick_id;
    logic              found;
    logic [WEIGHT_W-1:0] w_raw;
    logic [WEIGHT_W-1:0] w_new;
    logic              hold;

    assign nxt = (gnt_id == IDX_W'(PORTS-1)) ? '0 : gnt_id + 1'b1;

    // When a grant is ending, the scan already starts past the owner so
    // the hand-over happens in the same edge.
    assign scan_ptr = (state == GRANT) ? nxt : ptr;

    rr_pick #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (scan_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .found   (found)
    );

    assign w_raw = weight[pick_id*WEIGHT_W +: WEIGHT_W];
    assign w_new = (mode == MODE_WRR && w_raw != '0) ? w_raw : WEIGHT_W'(1);

    // cnt counts cycles already held beyond the first, so both bounds are
    // compared against cnt+1.
    assign hold = req[gnt_id] &&
                  ((32'(cnt) + 1 < 32'(weff)) ||
                   (lock[gnt_id] && (32'(cnt) + 1 < MAX_LOCK)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            weff      <= WEIGHT_W'(1);
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            gnt_start <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    gnt_start <= 1'b0;
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= pick;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_id;
                        gnt_start <= 1'b1;
                        cnt       <= '0;
                        weff      <= w_new;
                    end
                end
                GRANT: begin
                    if (hold) begin
                        cnt       <= cnt + 1'b1;
                        gnt_start <= 1'b0;
                    end else begin
                        ptr <= nxt;
                        if (found) begin
                            gnt       <= pick;
                            gnt_valid <= 1'b1;
                            gnt_id    <= pick_id;
                            gnt_start <= 1'b1;
                            cnt       <= '0;
                            weff      <= w_new;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                            gnt_start <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wrr_arbiter.sv
// Directed self-checking bench for mem_wrr_arbiter.
// Drives hand-computed vectors and checks grant outputs each cycle.
module tb_mem_wrr_arbiter;

    localparam int PORTS    = 16;
    localparam int WEIGHT_W = 4;
    localparam int MAX_LOCK = 8;
    localparam int IDX_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      mode = 1'b0;
    logic [PORTS-1:0]          req = '0;
    logic [PORTS-1:0]          lock = '0;
    logic [PORTS*WEIGHT_W-1:0] weight = '0;
    logic [PORTS-1:0]          gnt;
    logic                      gnt_valid;
    logic [IDX_W-1:0]          gnt_id;
    logic                      gnt_start;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_wrr_arbiter #(
        .PORTS    (PORTS),
        .WEIGHT_W (WEIGHT_W),
        .MAX_LOCK (MAX_LOCK),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req),
        .lock      (lock),
        .weight    (weight),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_start (gnt_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks all four outputs against one expected one-hot grant.
    task automatic expect_gnt(input string tag, input logic [15:0] eg,
                              input logic es);
        logic [3:0] eid;
        eid = '0;
        for (int i = 0; i < PORTS; i++) if (eg[i]) eid = 4'(i);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(|eg));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
        chk({tag, ".start"}, 32'(gnt_start), 32'(es));
    endtask

    initial begin
        int rr_seq[14];
        int wr_seq[8];
        logic wr_st[8];
        rr_seq = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 4, 5};
        wr_seq = '{1, 1, 1, 2, 1, 1, 1, 2};
        wr_st  = '{1, 0, 0, 1, 1, 0, 0, 1};

        // 1: reset holds grant off, then port 0 wins from ptr 0
        req = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_gnt("rst", 16'h0000, 1'b0);
        end
        rst = 1'b0;
        step();
        expect_gnt("rst_rel", 16'h0001, 1'b1);

        // 2: plain round-robin
        mode = 1'b0;
        req  = 16'hFFF0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("rr%0d.id", i), 32'(gnt_id), 32'(rr_seq[i]));
            chk($sformatf("rr%0d.st", i), 32'(gnt_start), 32'd1);
        end

        // 3: weighted, weight 3 vs weight 0 (treated as 1)
        mode = 1'b1;
        weight[1*WEIGHT_W +: WEIGHT_W] = 4'd3;
        weight[2*WEIGHT_W +: WEIGHT_W] = 4'd0;
        req = 16'h0006;
        for (int i = 0; i < 8; i++) begin
            step();
            expect_gnt($sformatf("wrr%0d", i),
                       16'(1 << wr_seq[i]), wr_st[i]);
        end

        // 4: lock holds port 0 for MAX_LOCK cycles
        mode = 1'b0;
        weight = '0;
        req  = 16'h0003;
        lock = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            step();
            expect_gnt($sformatf("lkA%0d", i), 16'h0001, i == 0);
        end
        step();
        expect_gnt("lk1", 16'h0002, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            expect_gnt($sformatf("lkB%0d", i), 16'h0001, i == 0);
        end

        // 5: early release hands over with no idle cycle
        mode = 1'b1;
        lock = '0;
        weight[3*WEIGHT_W +: WEIGHT_W] = 4'd5;
        req = 16'h0028;
        step();
        expect_gnt("er0", 16'h0008, 1'b1);
        step();
        expect_gnt("er1", 16'h0008, 1'b0);
        req = 16'h0020;
        step();
        expect_gnt("er_hand", 16'h0020, 1'b1);

        // 5b: sole requester re-granted every weight cycles
        req = 16'h0008;
        weight[3*WEIGHT_W +: WEIGHT_W] = 4'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_gnt($sformatf("sole%0d", i), 16'h0008, (i % 2) == 0);
        end

        // 6: reset in the middle of a lock burst on port 7
        mode = 1'b0;
        req  = 16'h0080;
        lock = 16'h0080;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_gnt($sformatf("mb%0d", i), 16'h0080, i == 0);
        end
        rst = 1'b1;
        step();
        expect_gnt("mb_rst", 16'h0000, 1'b0);
        rst  = 1'b0;
        lock = '0;
        req  = 16'h0081;
        step();
        expect_gnt("mb_after", 16'h0001, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
